ram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of the 1024x18 dual-port RAM (10-bit address, 18-bit data, per-port write enable, synchronous read) among NREQ requesters.
- Uses a valid/ready request handshake and an optional burst lock.
- Routes read data back to the originating requester with a response strobe.
- Port A and port B each get their own instance, placed between client logic and dual_port_ram.

---
 rtl/ram_arb_pkg.sv | 34 +++
 rtl/rr_grant.sv | 29 ++
 rtl/ram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: default RAM geometry,
// FSM state encoding and the round-robin pick helper used by rr_grant.
// The helper is sized for the largest supported requester count (8).
package ram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 18;
  localparam int MAXREQ = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // One-hot grant: first valid requester scanning upward from ptr, wrapping mod n
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                                input logic [2:0]        ptr,
                                                input int                n);
    logic [MAXREQ-1:0] g;
    logic              found;
    logic [2:0]        idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin priority picker.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the grant is only a function of valid and pointer.
module rr_grant
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_id
);

  logic [MAXREQ-1:0] w_gnt8;

  assign w_gnt8 = rr_pick(MAXREQ'(i_valid), 3'(i_ptr), NREQ);
  assign o_gnt  = NREQ'(w_gnt8);

  // Encode the one-hot grant into a requester index
  always_comb begin
    o_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (o_gnt[i]) o_id = PW'(i);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NREQ requesters.
// Latency: RAM signals registered on accept; read data returns 1+RAM_LAT cycles after accept.
// Backpressure: req_ready is one-hot and combinational; a locked owner excludes everyone else.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RAM_LAT   = 1,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic               ram_we,
  input  logic [DW-1:0]      ram_q,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_ram_data;
  logic            r_ram_we;
  logic [RAM_LAT:0] r_pl_vld;
  logic [PW-1:0]   r_pl_id [RAM_LAT+1];
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;

  logic [NREQ-1:0] w_pick_gnt;
  logic [PW-1:0]   w_pick_id;
  logic [NREQ-1:0] w_ready;
  logic [PW-1:0]   w_id;
  logic [PW-1:0]   w_id_nxt;
  logic            w_acc;
  logic            w_we;
  logic            w_lock;
  logic            w_last;

  rr_grant #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_grant (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_id    (w_pick_id)
  );

  // Grant selection: round-robin pick in ARB, owner only while LOCKED, nothing in reset
  always_comb begin
    w_ready = '0;
    w_id    = w_pick_id;
    if (r_state == LOCKED) begin
      w_id             = r_owner;
      w_ready[r_owner] = req_valid[r_owner];
    end else begin
      w_ready = w_pick_gnt;
    end
    if (!rst) w_ready = '0;
  end

  // The grant is already masked by valid, so any ready bit is an accepted beat
  assign w_acc     = |w_ready;
  assign w_we      = req_we[w_id];
  assign w_lock    = req_lock[w_id];
  assign w_id_nxt  = (w_id == PW'(NREQ - 1)) ? '0 : w_id + 1'b1;
  assign w_last    = (r_cnt + 1'b1) == CW'(MAX_BURST);
  assign req_ready = w_ready;

  // Arbitration FSM: pointer rotation, burst lock entry, and the three lock exits
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_acc) begin
            r_ptr <= w_id_nxt;
            if (w_lock && MAX_BURST > 1) begin
              r_state <= LOCKED;
              r_owner <= w_id;
              r_cnt   <= CW'(1);
            end
          end
        end
        LOCKED: begin
          // No accept while locked means the owner dropped valid
          if (!w_acc || !w_lock || w_last) begin
            r_state <= ARB;
            r_ptr   <= w_id_nxt;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // RAM port drive: address/data hold when idle, write enable only for an accepted write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ram_we <= w_acc & w_we;
      if (w_acc) begin
        r_ram_addr <= req_addr[w_id*AW +: AW];
        r_ram_data <= req_wdata[w_id*DW +: DW];
      end
    end
  end

  // Read tag pipeline: tracks {valid, id} until ram_q is ready to be captured
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pl_vld <= '0;
      for (int i = 0; i <= RAM_LAT; i++) r_pl_id[i] <= '0;
    end else begin
      r_pl_vld[0] <= w_acc & ~w_we;
      r_pl_id[0]  <= w_id;
      for (int i = 1; i <= RAM_LAT; i++) begin
        r_pl_vld[i] <= r_pl_vld[i-1];
        r_pl_id[i]  <= r_pl_id[i-1];
      end
    end
  end

  // Response register: one-cycle strobe to the originator, data held between strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (r_pl_vld[RAM_LAT]) begin
        r_rsp_valid[r_pl_id[RAM_LAT]] <= 1'b1;
        r_rsp_rdata                   <= ram_q;
      end
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_we    = r_ram_we;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (r_state == LOCKED) | (|r_pl_vld);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a transaction-level reference
// (grant rules, shadow memory, queue of pending read responses).
module tb_ram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 18;
  localparam int MAXB = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_data;
  logic               ram_we;
  logic [DW-1:0]      ram_q;
  logic               busy;

  ram_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .RAM_LAT(1), .MAX_BURST(MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Contents of a never-written location
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 32'h020) return 18'h2E995;
    return DW'((a * 7919 + 12345) ^ (a << 5));
  endfunction

  // Behavioural 1024x18 RAM port, write-first, one-cycle read latency
  logic [DW-1:0] ram_mem [1024];
  logic          ram_wr  [1024];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) ram_wr[i] <= 1'b0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_data;
      ram_wr[ram_addr]  <= 1'b1;
      ram_q             <= ram_data;
    end else begin
      ram_q <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
    end
  end

  // Reference model state
  typedef struct { int due; int id; logic [DW-1:0] d; } rsp_t;
  rsp_t          q[$];
  logic [DW-1:0] m_mem [1024];
  bit            m_wr  [1024];
  int            m_ptr, m_owner, m_cnt;
  bit            m_locked;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data, exp_rdata;
  int            cyc;
  int            glog[$];
  int            nrsp;
  logic [DW-1:0] last_rsp_dat;
  logic [NREQ-1:0] last_rsp_vld;
  int            n_chk = 0;
  int            n_fail = 0;
  int            exp_rr[5]  = '{0, 1, 2, 3, 0};
  int            exp_lk[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1};
  int            exp_rel[5] = '{0, 0, 0, -1, 2};
  bit            seen3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int a);
    return m_wr[a] ? m_mem[a] : init_val(a);
  endfunction

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_we[i]              = w;
    req_lock[i]            = l;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // One clock: predict and check the grant, advance the model, check registered outputs
  task automatic step();
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] erv;
    int              id;
    int              a;
    logic [DW-1:0]   wd;
    bit              acc, we, lk;
    er = '0; erv = '0; id = -1; a = 0; wd = '0; we = 0; lk = 0;
    #2;
    if (rst) begin
      if (m_locked) begin
        if (req_valid[m_owner]) begin er[m_owner] = 1'b1; id = m_owner; end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (id < 0 && req_valid[j]) begin er[j] = 1'b1; id = j; end
        end
      end
    end
    check_eq("req_ready", 32'(req_ready), 32'(er));
    acc = (id >= 0);
    glog.push_back(acc ? id : -1);
    if (acc) begin
      a  = int'(req_addr[id*AW +: AW]);
      wd = req_wdata[id*DW +: DW];
      we = req_we[id];
      lk = req_lock[id];
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
      q.delete();
      exp_we = 0; exp_addr = '0; exp_data = '0; exp_rdata = '0;
      for (int i = 0; i < 1024; i++) m_wr[i] = 0;
    end else begin
      if (acc) begin
        exp_we = we; exp_addr = AW'(a); exp_data = wd;
        if (we) begin m_mem[a] = wd; m_wr[a] = 1; end
        else q.push_back('{cyc + 2, id, exp_read(a)});
        if (!m_locked) begin
          m_ptr = (id + 1) % NREQ;
          if (lk) begin m_locked = 1; m_owner = id; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (!lk || m_cnt == MAXB) begin m_locked = 0; m_ptr = (m_owner + 1) % NREQ; end
        end
      end else begin
        exp_we = 0;
        if (m_locked) begin m_locked = 0; m_ptr = (m_owner + 1) % NREQ; end
      end
    end
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      erv[q[0].id] = 1'b1;
      exp_rdata    = q[0].d;
      void'(q.pop_front());
    end
    check_eq("ram_we",    32'(ram_we),    32'(exp_we));
    check_eq("ram_addr",  32'(ram_addr),  32'(exp_addr));
    check_eq("ram_data",  32'(ram_data),  32'(exp_data));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(erv));
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check_eq("busy",      32'(busy),      32'(m_locked || q.size() > 0));
    if (rsp_valid != '0) begin
      nrsp++;
      last_rsp_vld = rsp_valid;
      last_rsp_dat = rsp_rdata;
    end
  endtask

  task automatic do_reset();
    clear_req();
    rst = 1'b0;
    step();
    rst = 1'b1;
    glog.delete();
  endtask

  initial begin
    cyc = 0; nrsp = 0; last_rsp_dat = '0; last_rsp_vld = '0;
    m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
    exp_we = 0; exp_addr = '0; exp_data = '0; exp_rdata = '0;
    clear_req();
    rst = 1'b0;
    step();
    do_reset();

    // Single read after reset
    set_req(0, 1, 0, 0, 10'h020, '0);
    step();
    clear_req();
    repeat (3) step();
    check_eq("t1_grant", 32'(glog[0]), 32'(0));
    check_eq("t1_rsp_id", 32'(last_rsp_vld), 32'h1);
    check_eq("t1_rdata", 32'(last_rsp_dat), 32'h2E995);

    // Round-robin among four readers
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, AW'(16 * i), '0);
    repeat (5) step();
    clear_req();
    repeat (3) step();
    for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(glog[k]), 32'(exp_rr[k]));

    // Write then read of the same address
    set_req(2, 1, 1, 0, 10'h0AC, 18'h0A99D);
    step();
    set_req(2, 1, 0, 0, 10'h0AC, '0);
    step();
    clear_req();
    repeat (3) step();
    check_eq("wr_rd_id", 32'(last_rsp_vld), 32'h4);
    check_eq("wr_rd_data", 32'(last_rsp_dat), 32'h0A99D);

    // Lock with burst limit while requester 3 waits
    do_reset();
    seen3 = 0;
    for (int c = 0; c < 13; c++) begin
      set_req(1, 1, 0, 1, AW'(64 + c), '0);
      set_req(3, !seen3, 0, 0, 10'h100, '0);
      step();
      if (glog[glog.size() - 1] == 3) seen3 = 1;
    end
    clear_req();
    repeat (3) step();
    for (int k = 0; k < 10; k++) check_eq("burst_order", 32'(glog[k]), 32'(exp_lk[k]));

    // Lock released by dropping valid
    do_reset();
    repeat (3) begin
      set_req(0, 1, 1, 1, 10'h040, 18'h00001);
      set_req(2, 1, 0, 0, 10'h050, '0);
      step();
    end
    set_req(0, 0, 0, 0, '0, '0);
    step();
    step();
    clear_req();
    repeat (3) step();
    for (int k = 0; k < 5; k++) check_eq("release_order", 32'(glog[k]), 32'(exp_rel[k]));

    // Reset with reads in flight
    do_reset();
    set_req(1, 1, 0, 0, 10'h030, '0);
    step();
    step();
    rst = 1'b0;
    nrsp = 0;
    step();
    rst = 1'b1;
    clear_req();
    step();
    step();
    check_eq("rst_drop", 32'(nrsp), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, AW'(i), '0);
    step();
    clear_req();
    repeat (3) step();
    check_eq("post_rst_grant", 32'(glog[0]), 32'(0));

    // Randomized traffic with occasional resets
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)), DW'($urandom));
      step();
    end
    rst = 1'b1;
    clear_req();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
